lc3_decode_stage: RTL and testbench
===================================

// Module: lc3_decode_stage
// PURPOSE
//  Responder end of the decode_in bus: the LC3 Decode pipeline stage.
//  - Captures instr_dout/npc_in/psr from Fetch whenever enable_decode is high.
//  - Produces registered IR, npc_out and E/W/Mem control words for Execute and Writeback.
//  - Flags opcodes outside the supported subset.
// PARAMETERS
//  INSTR_W  16  instruction / PC width (LC3 fixed; parameterised for the bench only)
//  PSR_W    3   NZP flag width
// PORTS
//  clock          in   1        rising-edge clock
//  reset          in   1        synchronous, active-low reset
//  enable_decode  in   1        capture strobe from controller
//  instr_dout     in   INSTR_W  instruction word from Fetch/IMEM
//  npc_in         in   INSTR_W  PC+1 from Fetch
//  psr            in   PSR_W    current NZP flags
//  IR             out  INSTR_W  registered instruction
//  npc_out        out  INSTR_W  registered npc_in
//  psr_out        out  PSR_W    registered psr
//  E_Control      out  6        {alu_ctl[1:0], pcsel1[1:0], pcsel2, op2sel}
//  W_Control      out  2        00 aluout, 01 memout, 10 pcout
//  Mem_Control    out  1        1 = indirect access (LDI/STI)
//  decode_valid   out  1        outputs hold a freshly decoded instruction
//  illegal_op     out  1        registered: captured opcode unsupported
// BEHAVIOUR
//  - Reset (reset==0 at posedge): every output goes to 0 on that edge; reset wins over enable_decode.
//  - Latency: 1 cycle. Posedge with enable_decode=1 loads IR, npc_out, psr_out and decoded controls.
//  - enable_decode=0: all data/control registers hold. decode_valid <= enable_decode every cycle.
//  - Back-to-back enables: each edge loads a new instruction. No bubble, no skid storage.
//  - alu_ctl: ADD 00, AND 01, NOT 10; all other opcodes 00.
//  - op2sel: ADD/AND = ~instr[5] (1 = VSR2, 0 = imm5); all other opcodes 0.
//  - pcsel1: 01 offset9 (BR, LD, LDI, LEA, ST, STI); 10 offset6 (LDR, STR); 11 zero (JMP); else 00.
//  - pcsel2: 1 = npc (BR, LD, LDI, LEA, ST, STI); 0 = VSR1 (JMP, LDR, STR, ALU ops).
//  - W_Control: ADD/AND/NOT 00; LD/LDR/LDI 01; LEA 10; BR/JMP/ST/STR/STI 00.
//  - Mem_Control: 1 only for LDI/STI.
//  - Unsupported opcodes (JSR 0100, RTI 1000, 1101, TRAP 1111):
//    IR/npc_out/psr_out still load; E/W/Mem load 0; illegal_op=1 until next capture or reset.
//  - Reset mid-stream: pending capture discarded; first enable after reset release loads normally.
// CONFIGURATION
//  LC3_DECODE_PERF_EN defined:
//  - Adds output port decode_count [15:0].
//  - Counter increments on each capture edge and saturates at 16'hFFFF.
//  - Reset to 0; illegal opcodes are counted as well.
//  LC3_DECODE_PERF_EN undefined: no port and no counter logic.
// STRUCTURE
//  - Package lc3_decode_pkg:
//    - opcode_t enum (ADD=4'b0001 ... LEA=4'b1110).
//    - e_ctl_t packed struct, w_ctl_t enum.
//    - Localparams for the pcsel1/pcsel2/op2sel encodings.
//  - Sub-module lc3_decode_ctrl (combinational): instr -> {e_ctl, w_ctl, mem_ctl, illegal}.
//    The top holds only the registers and the optional counter.
// TESTING
//  - Reset: hold reset=0 two cycles with enable=1 -> all outputs 0, decode_valid 0.
//  - ADD R1,R2,R3 (16'h1283), npc 16'h3001, en=1 -> next cycle:
//    IR=1283, npc_out=3001, E=6'b000001, W=00, Mem=0, valid=1.
//  - ADD imm then hold: 16'h12A5, en=1, then en=0 for 3 cycles ->
//    E=6'b000000 held, valid drops to 0 after 1 cycle.
//  - LDR 16'h6285 -> E=6'b001000, W=01, Mem=0.
//    Then LDI 16'hA205 back-to-back -> E=6'b000110, W=01, Mem=1.
//  - Illegal 16'hD000 -> illegal_op=1, E/W/Mem=0, IR=D000.
//    Next capture JMP 16'hC1C0 -> illegal_op=0, E=6'b001100.
//  - PERF_EN: 70000 consecutive captures -> decode_count=16'hFFFF (saturated).
//    Reset mid-run -> 0.

Source files
------------

// File: rtl/lc3_decode_pkg.sv
// Shared types and encodings for the LC3 Decode stage.
// Optional feature macro used by the top: LC3_DECODE_PERF_EN.
package lc3_decode_pkg;

  typedef enum logic [3:0] {
    OP_BR   = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LD   = 4'b0010,
    OP_ST   = 4'b0011,
    OP_JSR  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_LDR  = 4'b0110,
    OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_LDI  = 4'b1010,
    OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_RSVD = 4'b1101,
    OP_LEA  = 4'b1110,
    OP_TRAP = 4'b1111
  } opcode_t;

  typedef struct packed {
    logic [1:0] alu_ctl;
    logic [1:0] pcsel1;
    logic       pcsel2;
    logic       op2sel;
  } e_ctl_t;

  typedef enum logic [1:0] {
    W_ALUOUT = 2'b00,
    W_MEMOUT = 2'b01,
    W_PCOUT  = 2'b10
  } w_ctl_t;

  localparam logic [1:0] ALU_ADD     = 2'b00;
  localparam logic [1:0] ALU_AND     = 2'b01;
  localparam logic [1:0] ALU_NOT     = 2'b10;
  localparam logic [1:0] PCSEL1_NONE = 2'b00;
  localparam logic [1:0] PCSEL1_OFF9 = 2'b01;
  localparam logic [1:0] PCSEL1_OFF6 = 2'b10;
  localparam logic [1:0] PCSEL1_ZERO = 2'b11;
  localparam logic       PCSEL2_VSR1 = 1'b0;
  localparam logic       PCSEL2_NPC  = 1'b1;
  localparam logic       OP2SEL_IMM5 = 1'b0;
  localparam logic       OP2SEL_VSR2 = 1'b1;

  // Bit 5 of ADD/AND clear means the second operand comes from a register.
  function automatic logic op2_from_reg(input logic imm_flag);
    return imm_flag ? OP2SEL_IMM5 : OP2SEL_VSR2;
  endfunction

endpackage

// File: rtl/lc3_decode_if.sv
// decode_in bus between Fetch/controller (master) and the Decode stage (slave).
interface lc3_decode_if #(
  parameter int INSTR_W = 16,
  parameter int PSR_W   = 3
);
  logic               enable_decode;
  logic [INSTR_W-1:0] instr_dout;
  logic [INSTR_W-1:0] npc_in;
  logic [PSR_W-1:0]   psr;
  logic [INSTR_W-1:0] IR;
  logic [INSTR_W-1:0] npc_out;
  logic [PSR_W-1:0]   psr_out;
  logic [5:0]         E_Control;
  logic [1:0]         W_Control;
  logic               Mem_Control;
  logic               decode_valid;
  logic               illegal_op;

  modport master (
    output enable_decode, instr_dout, npc_in, psr,
    input  IR, npc_out, psr_out, E_Control, W_Control, Mem_Control,
           decode_valid, illegal_op
  );

  modport slave (
    input  enable_decode, instr_dout, npc_in, psr,
    output IR, npc_out, psr_out, E_Control, W_Control, Mem_Control,
           decode_valid, illegal_op
  );
endinterface

// File: rtl/lc3_decode_ctrl.sv
// Combinational opcode decoder: opcode and imm flag -> Execute/Writeback/Memory controls.
module lc3_decode_ctrl
  import lc3_decode_pkg::*;
(
  input  logic [3:0] i_opcode,
  input  logic       i_imm_flag,
  output e_ctl_t     o_e_ctl,
  output w_ctl_t     o_w_ctl,
  output logic       o_mem_ctl,
  output logic       o_illegal
);

  opcode_t w_op;
  assign w_op = opcode_t'(i_opcode);

  // Unsupported opcodes leave every control field at zero and raise o_illegal.
  always_comb begin
    o_e_ctl   = '0;
    o_w_ctl   = W_ALUOUT;
    o_mem_ctl = 1'b0;
    o_illegal = 1'b0;
    case (w_op)
      OP_ADD: begin
        o_e_ctl.alu_ctl = ALU_ADD;
        o_e_ctl.op2sel  = op2_from_reg(i_imm_flag);
      end
      OP_AND: begin
        o_e_ctl.alu_ctl = ALU_AND;
        o_e_ctl.op2sel  = op2_from_reg(i_imm_flag);
      end
      OP_NOT: o_e_ctl.alu_ctl = ALU_NOT;
      OP_BR, OP_ST: begin
        o_e_ctl.pcsel1 = PCSEL1_OFF9;
        o_e_ctl.pcsel2 = PCSEL2_NPC;
      end
      OP_LD: begin
        o_e_ctl.pcsel1 = PCSEL1_OFF9;
        o_e_ctl.pcsel2 = PCSEL2_NPC;
        o_w_ctl        = W_MEMOUT;
      end
      OP_LDI: begin
        o_e_ctl.pcsel1 = PCSEL1_OFF9;
        o_e_ctl.pcsel2 = PCSEL2_NPC;
        o_w_ctl        = W_MEMOUT;
        o_mem_ctl      = 1'b1;
      end
      OP_STI: begin
        o_e_ctl.pcsel1 = PCSEL1_OFF9;
        o_e_ctl.pcsel2 = PCSEL2_NPC;
        o_mem_ctl      = 1'b1;
      end
      OP_LEA: begin
        o_e_ctl.pcsel1 = PCSEL1_OFF9;
        o_e_ctl.pcsel2 = PCSEL2_NPC;
        o_w_ctl        = W_PCOUT;
      end
      OP_LDR: begin
        o_e_ctl.pcsel1 = PCSEL1_OFF6;
        o_e_ctl.pcsel2 = PCSEL2_VSR1;
        o_w_ctl        = W_MEMOUT;
      end
      OP_STR: begin
        o_e_ctl.pcsel1 = PCSEL1_OFF6;
        o_e_ctl.pcsel2 = PCSEL2_VSR1;
      end
      OP_JMP: begin
        o_e_ctl.pcsel1 = PCSEL1_ZERO;
        o_e_ctl.pcsel2 = PCSEL2_VSR1;
      end
      OP_JSR, OP_RTI, OP_RSVD, OP_TRAP: o_illegal = 1'b1;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/lc3_decode_stage.sv
// LC3 Decode pipeline stage: registers the Fetch word and its decoded controls.
// Optional capture counter enabled by defining LC3_DECODE_PERF_EN.
module lc3_decode_stage
  import lc3_decode_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int PSR_W   = 3
) (
  input  logic        clock,
  input  logic        reset,
  lc3_decode_if.slave bus
`ifdef LC3_DECODE_PERF_EN
  ,
  output logic [15:0] decode_count
`endif
);

  e_ctl_t w_e_ctl;
  w_ctl_t w_w_ctl;
  logic   w_mem_ctl;
  logic   w_illegal;

  lc3_decode_ctrl u_ctrl (
    .i_opcode   (bus.instr_dout[INSTR_W-1 -: 4]),
    .i_imm_flag (bus.instr_dout[5]),
    .o_e_ctl    (w_e_ctl),
    .o_w_ctl    (w_w_ctl),
    .o_mem_ctl  (w_mem_ctl),
    .o_illegal  (w_illegal)
  );

  logic [INSTR_W-1:0] r_ir;
  logic [INSTR_W-1:0] r_npc;
  logic [PSR_W-1:0]   r_psr;
  e_ctl_t             r_e_ctl;
  w_ctl_t             r_w_ctl;
  logic               r_mem_ctl;
  logic               r_valid;
  logic               r_illegal;

  // Capture on enable; everything holds otherwise, valid tracks the strobe.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_ir      <= '0;
      r_npc     <= '0;
      r_psr     <= '0;
      r_e_ctl   <= '0;
      r_w_ctl   <= W_ALUOUT;
      r_mem_ctl <= 1'b0;
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_valid <= bus.enable_decode;
      if (bus.enable_decode) begin
        r_ir      <= bus.instr_dout;
        r_npc     <= bus.npc_in;
        r_psr     <= bus.psr;
        r_e_ctl   <= w_e_ctl;
        r_w_ctl   <= w_w_ctl;
        r_mem_ctl <= w_mem_ctl;
        r_illegal <= w_illegal;
      end
    end
  end

  assign bus.IR           = r_ir;
  assign bus.npc_out      = r_npc;
  assign bus.psr_out      = r_psr;
  assign bus.E_Control    = r_e_ctl;
  assign bus.W_Control    = r_w_ctl;
  assign bus.Mem_Control  = r_mem_ctl;
  assign bus.decode_valid = r_valid;
  assign bus.illegal_op   = r_illegal;

`ifdef LC3_DECODE_PERF_EN
  logic [15:0] r_count;

  // Saturating count of capture edges, illegal opcodes included.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_count <= 16'd0;
    end else if (bus.enable_decode && (r_count != 16'hFFFF)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign decode_count = r_count;
`endif

endmodule

// File: tb/tb_lc3_decode_stage.sv
// Self-checking bench for lc3_decode_stage: directed scenarios plus randomized traffic vs a reference model.
module tb_lc3_decode_stage;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  lc3_decode_if #(.INSTR_W(16), .PSR_W(3)) bus ();
`ifdef LC3_DECODE_PERF_EN
  logic [15:0] decode_count;
`endif

  lc3_decode_stage #(.INSTR_W(16), .PSR_W(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef LC3_DECODE_PERF_EN
    ,
    .decode_count (decode_count)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state (expected registered outputs).
  logic [15:0] m_ir, m_npc;
  logic [2:0]  m_psr;
  logic [5:0]  m_e;
  logic [1:0]  m_w;
  logic        m_mem, m_valid, m_ill;

  // Expected {illegal, mem, w[1:0], e[5:0]} from the opcode rule table.
  function automatic logic [9:0] ref_ctl(input logic [15:0] ins);
    int op;
    logic [1:0] alu, ps1, w;
    logic ps2, op2, mem;
    op = int'(ins[15:12]);
    if (op == 4 || op == 8 || op == 13 || op == 15) return {1'b1, 9'd0};
    alu = (op == 1) ? 2'd0 : (op == 5) ? 2'd1 : (op == 9) ? 2'd2 : 2'd0;
    op2 = (op == 1 || op == 5) ? ~ins[5] : 1'b0;
    ps2 = (op == 0 || op == 2 || op == 3 || op == 10 || op == 11 || op == 14);
    ps1 = ps2 ? 2'd1 : (op == 6 || op == 7) ? 2'd2 : (op == 12) ? 2'd3 : 2'd0;
    w   = (op == 2 || op == 6 || op == 10) ? 2'd1 : (op == 14) ? 2'd2 : 2'd0;
    mem = (op == 10 || op == 11);
    return {1'b0, mem, w, alu, ps1, ps2, op2};
  endfunction

  task automatic step(input logic rst, input logic en, input logic [15:0] ins,
                      input logic [15:0] npc, input logic [2:0] p);
    @(negedge clock);
    reset             = rst;
    bus.enable_decode = en;
    bus.instr_dout    = ins;
    bus.npc_in        = npc;
    bus.psr           = p;
    @(posedge clock);
    if (!rst) begin
      {m_ir, m_npc, m_psr, m_e, m_w, m_mem, m_valid, m_ill} = '0;
    end else begin
      m_valid = en;
      if (en) begin
        m_ir  = ins;
        m_npc = npc;
        m_psr = p;
        {m_ill, m_mem, m_w, m_e} = ref_ctl(ins);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    logic [45:0] got;
    step(1'b0, 1'b1, 16'h1283, 16'h3001, 3'b010);
    step(1'b0, 1'b1, 16'h1283, 16'h3001, 3'b010);
    got = {bus.IR, bus.npc_out, bus.psr_out, bus.E_Control, bus.W_Control,
           bus.Mem_Control, bus.decode_valid, bus.illegal_op};
    checks++;
    if (got !== 46'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h exp 0", got);
    end
  endtask

  task automatic test_add();
    step(1'b1, 1'b1, 16'h1283, 16'h3001, 3'b001);
    checks++;
    if ({bus.IR, bus.npc_out, bus.psr_out, bus.E_Control, bus.W_Control, bus.Mem_Control,
         bus.decode_valid, bus.illegal_op} !==
        {16'h1283, 16'h3001, 3'b001, 6'b000001, 2'b00, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL add_reg: IR=%h npc=%h psr=%b E=%b W=%b Mem=%b v=%b ill=%b exp 1283 3001 001 000001 00 0 1 0",
               bus.IR, bus.npc_out, bus.psr_out, bus.E_Control, bus.W_Control,
               bus.Mem_Control, bus.decode_valid, bus.illegal_op);
    end
  endtask

  task automatic test_hold();
    step(1'b1, 1'b1, 16'h12A5, 16'h3002, 3'b100);
    checks++;
    if ({bus.IR, bus.E_Control, bus.decode_valid} !== {16'h12A5, 6'b000000, 1'b1}) begin
      failures++;
      $display("FAIL add_imm: IR=%h E=%b v=%b exp 12a5 000000 1", bus.IR, bus.E_Control, bus.decode_valid);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 16'($urandom), 16'($urandom), 3'($urandom));
      checks++;
      if ({bus.IR, bus.npc_out, bus.psr_out, bus.E_Control, bus.decode_valid} !==
          {16'h12A5, 16'h3002, 3'b100, 6'b000000, 1'b0}) begin
        failures++;
        $display("FAIL hold_%0d: IR=%h npc=%h psr=%b E=%b v=%b exp 12a5 3002 100 000000 0",
                 i, bus.IR, bus.npc_out, bus.psr_out, bus.E_Control, bus.decode_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b1, 16'h6285, 16'h3010, 3'b010);
    checks++;
    if ({bus.E_Control, bus.W_Control, bus.Mem_Control, bus.decode_valid} !== {6'b001000, 2'b01, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL ldr: E=%b W=%b Mem=%b v=%b exp 001000 01 0 1",
               bus.E_Control, bus.W_Control, bus.Mem_Control, bus.decode_valid);
    end
    step(1'b1, 1'b1, 16'hA205, 16'h3011, 3'b001);
    checks++;
    if ({bus.IR, bus.E_Control, bus.W_Control, bus.Mem_Control, bus.decode_valid} !==
        {16'hA205, 6'b000110, 2'b01, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL ldi_b2b: IR=%h E=%b W=%b Mem=%b v=%b exp a205 000110 01 1 1",
               bus.IR, bus.E_Control, bus.W_Control, bus.Mem_Control, bus.decode_valid);
    end
  endtask

  task automatic test_illegal();
    logic [15:0] ill_ops [4] = '{16'hD000, 16'h4ABC, 16'h8000, 16'hF025};
    foreach (ill_ops[k]) begin
      step(1'b1, 1'b1, ill_ops[k], 16'h3020, 3'b010);
      checks++;
      if ({bus.IR, bus.illegal_op, bus.E_Control, bus.W_Control, bus.Mem_Control} !==
          {ill_ops[k], 1'b1, 6'd0, 2'd0, 1'b0}) begin
        failures++;
        $display("FAIL illegal_%h: IR=%h ill=%b E=%b W=%b Mem=%b exp ill=1 controls 0",
                 ill_ops[k], bus.IR, bus.illegal_op, bus.E_Control, bus.W_Control, bus.Mem_Control);
      end
    end
    step(1'b1, 1'b0, 16'h1111, 16'h0000, 3'b000);
    checks++;
    if (bus.illegal_op !== 1'b1) begin
      failures++;
      $display("FAIL illegal_hold: ill=%b exp 1", bus.illegal_op);
    end
    step(1'b1, 1'b1, 16'hC1C0, 16'h3021, 3'b100);
    checks++;
    if ({bus.illegal_op, bus.E_Control, bus.W_Control} !== {1'b0, 6'b001100, 2'b00}) begin
      failures++;
      $display("FAIL jmp_clear: ill=%b E=%b W=%b exp 0 001100 00", bus.illegal_op, bus.E_Control, bus.W_Control);
    end
  endtask

  task automatic test_reset_midstream();
    step(1'b1, 1'b1, 16'h2205, 16'h3030, 3'b001);
    step(1'b0, 1'b1, 16'hE1FF, 16'h3031, 3'b010);
    checks++;
    if ({bus.IR, bus.npc_out, bus.E_Control, bus.W_Control, bus.decode_valid} !== 41'd0) begin
      failures++;
      $display("FAIL mid_reset: IR=%h npc=%h E=%b W=%b v=%b exp all 0",
               bus.IR, bus.npc_out, bus.E_Control, bus.W_Control, bus.decode_valid);
    end
    step(1'b1, 1'b1, 16'h967F, 16'h3032, 3'b100);
    checks++;
    if ({bus.IR, bus.npc_out, bus.E_Control, bus.decode_valid} !== {16'h967F, 16'h3032, 6'b100000, 1'b1}) begin
      failures++;
      $display("FAIL post_reset_not: IR=%h npc=%h E=%b v=%b exp 967f 3032 100000 1",
               bus.IR, bus.npc_out, bus.E_Control, bus.decode_valid);
    end
  endtask

  task automatic test_random();
    logic [45:0] got, exp;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(99) >= 3), ($urandom_range(99) < 70),
           16'($urandom), 16'($urandom), 3'($urandom));
      got = {bus.IR, bus.npc_out, bus.psr_out, bus.E_Control, bus.W_Control,
             bus.Mem_Control, bus.decode_valid, bus.illegal_op};
      exp = {m_ir, m_npc, m_psr, m_e, m_w, m_mem, m_valid, m_ill};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL random_%0d: got %h exp %h", i, got, exp);
      end
    end
  endtask

`ifdef LC3_DECODE_PERF_EN
  task automatic test_perf();
    step(1'b0, 1'b1, 16'h1283, 16'h0000, 3'b000);
    checks++;
    if (decode_count !== 16'd0) begin
      failures++;
      $display("FAIL perf_reset: count=%h exp 0000", decode_count);
    end
    step(1'b1, 1'b1, 16'hD000, 16'h0001, 3'b000);
    step(1'b1, 1'b0, 16'h1283, 16'h0002, 3'b000);
    step(1'b1, 1'b1, 16'h1283, 16'h0003, 3'b000);
    checks++;
    if (decode_count !== 16'd2) begin
      failures++;
      $display("FAIL perf_small: count=%h exp 0002", decode_count);
    end
    for (int i = 0; i < 70000; i++) step(1'b1, 1'b1, 16'($urandom), 16'(i), 3'b001);
    checks++;
    if (decode_count !== 16'hFFFF) begin
      failures++;
      $display("FAIL perf_saturate: count=%h exp ffff", decode_count);
    end
    step(1'b0, 1'b1, 16'h1283, 16'h0000, 3'b000);
    checks++;
    if (decode_count !== 16'd0) begin
      failures++;
      $display("FAIL perf_midreset: count=%h exp 0000", decode_count);
    end
  endtask
`endif

  initial begin
    bus.enable_decode = 1'b0;
    bus.instr_dout    = 16'h0000;
    bus.npc_in        = 16'h0000;
    bus.psr           = 3'b000;
    test_reset();
    test_add();
    test_hold();
    test_back_to_back();
    test_illegal();
    test_reset_midstream();
    test_random();
`ifdef LC3_DECODE_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
